// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: default widths, requester port ids and the command record.
package sdram_pkg;

    localparam int SDRAM_AW = 24;
    localparam int SDRAM_DW = 16;

    localparam logic PORT_VID = 1'b0;
    localparam logic PORT_CPU = 1'b1;

    typedef struct packed {
        logic                we;
        logic [SDRAM_AW-1:0] addr;
        logic [SDRAM_DW-1:0] wdata;
        logic [1:0]          dqm;
    } sdram_cmd_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Tag FIFO remembering which port issued each outstanding read, oldest at the head.
// Push while full and pop while empty are ignored; simultaneous push/pop keeps the count.
module sdram_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sdram_port_arb.sv
// Two-port arbiter in front of the SDRAM controller command port, with read-tag routing.
// SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins ties (no last_grant); undefined = round-robin.
module sdram_port_arb
    import sdram_pkg::*;
#(
    parameter int AW        = SDRAM_AW,
    parameter int DW        = SDRAM_DW,
    parameter int TAG_DEPTH = 4
) (
    input  logic          CLOCK_100,
    input  logic          rst,
    input  logic          p0_valid,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [1:0]    p0_dqm,
    output logic          p0_ready,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_valid,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic [1:0]    p1_dqm,
    output logic          p1_ready,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          cmd_we,
    output logic [AW-1:0] cmd_addr,
    output logic [DW-1:0] cmd_wdata,
    output logic [1:0]    cmd_dqm,
    input  logic          rsp_valid,
    input  logic [DW-1:0] rsp_data,
    output logic          tag_err
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    dqm;
    } cmd_t;

    cmd_t req0;
    cmd_t req1;
    cmd_t sel_cmd;
    logic grant;        // granted port id
    logic block;
    logic accept;
    logic tag_head;
    logic tag_full;
    logic tag_empty;
    logic tag_push;
    logic tag_pop;

    assign req0 = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, dqm: p0_dqm};
    assign req1 = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, dqm: p1_dqm};

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = PORT_VID;
        if (p1_valid && !p0_valid) begin
            grant = PORT_CPU;
        end
    end
`else
    logic last_grant;

    always_comb begin
        grant = PORT_VID;
        if (p1_valid && !p0_valid) begin
            grant = PORT_CPU;
        end else if (p0_valid && p1_valid) begin
            grant = ~last_grant;
        end
    end

    always_ff @(posedge CLOCK_100) begin
        if (rst) begin
            last_grant <= PORT_CPU;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`endif

    assign sel_cmd = (grant == PORT_CPU) ? req1 : req0;

    // Only reads need a tag slot; writes always pass even with the FIFO full.
    assign block     = tag_full & ~sel_cmd.we;
    assign cmd_valid = (p0_valid | p1_valid) & ~rst & ~block;
    assign accept    = cmd_valid & cmd_ready;

    assign p0_ready  = accept & (grant == PORT_VID);
    assign p1_ready  = accept & (grant == PORT_CPU);

    assign cmd_we    = sel_cmd.we;
    assign cmd_addr  = sel_cmd.addr;
    assign cmd_wdata = sel_cmd.wdata;
    assign cmd_dqm   = sel_cmd.dqm;

    assign tag_push  = accept & ~sel_cmd.we;
    assign tag_pop   = rsp_valid;

    sdram_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (CLOCK_100),
        .rst   (rst),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (grant),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_ff @(posedge CLOCK_100) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            tag_err   <= 1'b0;
        end else begin
            p0_rvalid <= rsp_valid & ~tag_empty & (tag_head == PORT_VID);
            p1_rvalid <= rsp_valid & ~tag_empty & (tag_head == PORT_CPU);
            if (rsp_valid) begin
                p0_rdata <= rsp_data;
                p1_rdata <= rsp_data;
            end
            // A response with nothing outstanding is dropped and latched as an error.
            if (rsp_valid && tag_empty) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: vector table, directed corner sequences and random traffic vs a queue model.
module tb_sdram_port_arb;
    import sdram_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_valid, p1_valid, p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic [1:0]    p0_dqm, p1_dqm;
    logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [1:0]    cmd_dqm;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          tag_err;

    always #5 clk = ~clk;

    sdram_port_arb #(.AW(AW), .DW(DW), .TAG_DEPTH(TD)) dut (
        .CLOCK_100(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_dqm(p0_dqm), .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_dqm(p1_dqm), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_dqm(cmd_dqm),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tag_err(tag_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: list of outstanding read owners plus who was served last.
    bit            m_last;
    bit            m_tags[$];
    bit            m_rv0, m_rv1, m_err;
    logic [DW-1:0] m_rd0, m_rd1;
    bit            e_cv, e_r0, e_r1, e_we;
    int            e_sel;

    // Actual DUT outputs sampled at the last negedge.
    bit            a_cv, a_r0, a_r1, a_rv0, a_rv1, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rd0, a_rd1;
    int            order[$];
    logic [DW-1:0] got0[$];
    logic [DW-1:0] got1[$];

    function automatic void predict();
        bit both;
        both = p0_valid && p1_valid;
        if (both) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            e_sel = 0;
`else
            e_sel = 1 - int'(m_last);
`endif
        end else begin
            e_sel = p1_valid ? 1 : 0;
        end
        e_we = (e_sel == 1) ? p1_we : p0_we;
        e_cv = (p0_valid || p1_valid) && !rst && !(m_tags.size() == TD && !e_we);
        e_r0 = e_cv && cmd_ready && e_sel == 0;
        e_r1 = e_cv && cmd_ready && e_sel == 1;
    endfunction

    function automatic void advance();
        bit h;
        if (rst) begin
            m_tags.delete();
            m_last = 1'b1;
            m_rv0 = 0; m_rv1 = 0; m_err = 0;
            m_rd0 = '0; m_rd1 = '0;
        end else begin
            m_rv0 = 0; m_rv1 = 0;
            if (rsp_valid) begin
                m_rd0 = rsp_data;
                m_rd1 = rsp_data;
                if (m_tags.size() > 0) begin
                    h = m_tags.pop_front();
                    if (h) m_rv1 = 1; else m_rv0 = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (e_cv && cmd_ready) begin
                if (!e_we) m_tags.push_back(e_sel[0]);
                m_last = e_sel[0];
            end
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        predict();
        a_cv = cmd_valid; a_r0 = p0_ready; a_r1 = p1_ready;
        a_rv0 = p0_rvalid; a_rv1 = p1_rvalid; a_err = tag_err;
        a_addr = cmd_addr; a_rd0 = p0_rdata; a_rd1 = p1_rdata;
        if (a_r0) order.push_back(0);
        if (a_r1) order.push_back(1);
        if (a_rv0) got0.push_back(a_rd0);
        if (a_rv1) got1.push_back(a_rd1);
        chk("cmd_valid", cmd_valid, e_cv);
        chk("p0_ready", p0_ready, e_r0);
        chk("p1_ready", p1_ready, e_r1);
        chk("p0_rvalid", p0_rvalid, m_rv0);
        chk("p1_rvalid", p1_rvalid, m_rv1);
        chk("p0_rdata", p0_rdata, m_rd0);
        chk("p1_rdata", p1_rdata, m_rd1);
        chk("tag_err", tag_err, m_err);
        if (e_cv) begin
            chk("cmd_we", cmd_we, e_we);
            chk("cmd_addr", cmd_addr, (e_sel == 1) ? p1_addr : p0_addr);
            chk("cmd_wdata", cmd_wdata, (e_sel == 1) ? p1_wdata : p0_wdata);
            chk("cmd_dqm", cmd_dqm, (e_sel == 1) ? p1_dqm : p0_dqm);
        end
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_valid = 0; p1_valid = 0; p0_we = 0; p1_we = 0;
        rsp_valid = 0; rsp_data = '0; cmd_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    typedef struct {
        bit rst, v0, v1, we0, we1, crdy;
        bit cv, r0, r1;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cnt0, cnt1, budget;
        rst = 1;
        idle_inputs();
        p0_addr = 24'h000010; p1_addr = 24'h000020;
        p0_wdata = 16'h1111; p1_wdata = 16'h2222;
        p0_dqm = 2'b00; p1_dqm = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        e_cv = 0;
        advance();
        // reset state: cmd_valid held low by rst even with requests present
        p0_valid = 1; p1_valid = 1;
        cycle();
        chk("reset_cmd_valid", a_cv, 0);
        chk("reset_tag_err", a_err, 0);
        chk("reset_rvalid", {a_rv0, a_rv1}, 2'b00);
        rst = 0;

        //              rst v0 v1 we0 we1 crdy  cv r0 r1
        tbl[0]  = '{0, 1, 1, 0, 0, 1,   1, 1, 0};
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        tbl[1]  = '{0, 1, 1, 0, 0, 1,   1, 1, 0};
`else
        tbl[1]  = '{0, 1, 1, 0, 0, 1,   1, 0, 1};
`endif
        tbl[2]  = '{0, 1, 1, 0, 0, 0,   1, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 1,   1, 1, 0};
        tbl[4]  = '{0, 0, 1, 0, 1, 1,   1, 0, 1};
        tbl[5]  = '{0, 1, 0, 0, 0, 1,   1, 1, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 1,   0, 0, 0};
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        tbl[7]  = '{0, 1, 1, 1, 0, 1,   1, 1, 0};
        tbl[8]  = '{0, 1, 1, 1, 1, 1,   1, 1, 0};
`else
        tbl[7]  = '{0, 1, 1, 1, 0, 1,   0, 0, 0};
        tbl[8]  = '{0, 1, 1, 1, 1, 1,   1, 0, 1};
`endif
        tbl[9]  = '{0, 0, 0, 0, 0, 1,   0, 0, 0};
        tbl[10] = '{1, 1, 1, 0, 0, 1,   0, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 1,   1, 1, 0};

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; p0_valid = tbl[i].v0; p1_valid = tbl[i].v1;
            p0_we = tbl[i].we0; p1_we = tbl[i].we1; cmd_ready = tbl[i].crdy;
            cycle();
            chk($sformatf("vec%0d_cv", i), a_cv, tbl[i].cv);
            chk($sformatf("vec%0d_rdy", i), {a_r0, a_r1}, {tbl[i].r0, tbl[i].r1});
        end

        // alternating reads, then in-order responses routed to their owners
        do_reset();
        order.delete(); got0.delete(); got1.delete();
        cnt0 = 0; cnt1 = 0; budget = 0;
        while ((cnt0 < 2 || cnt1 < 2) && budget < 20) begin
            p0_valid = (cnt0 < 2); p1_valid = (cnt1 < 2);
            p0_we = 0; p1_we = 0;
            cycle();
            if (e_r0) cnt0++;
            if (e_r1) cnt1++;
            budget++;
        end
        chk("seq1_budget", budget < 20, 1);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            rsp_valid = 1; rsp_data = 16'hA000 + 16'(i);
            cycle();
        end
        rsp_valid = 0;
        cycle();
        cycle();
        while (order.size() < 4) order.push_back(-1);
        while (got0.size() < 2) got0.push_back('0);
        while (got1.size() < 2) got1.push_back('0);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        chk("seq1_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0011);
        chk("seq1_p0_data0", got0[0], 16'hA000);
        chk("seq1_p0_data1", got0[1], 16'hA001);
        chk("seq1_p1_data0", got1[0], 16'hA002);
        chk("seq1_p1_data1", got1[1], 16'hA003);
`else
        chk("seq1_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
        chk("seq1_p0_data0", got0[0], 16'hA000);
        chk("seq1_p0_data1", got0[1], 16'hA002);
        chk("seq1_p1_data0", got1[0], 16'hA001);
        chk("seq1_p1_data1", got1[1], 16'hA003);
`endif

        // full tag FIFO blocks a fifth read, but not a write
        cnt1 = 0; budget = 0;
        while (cnt1 < 4 && budget < 20) begin
            p1_valid = 1; p1_we = 0; p1_addr = 24'h000040 + 24'(cnt1);
            cycle();
            if (e_r1) cnt1++;
            budget++;
        end
        chk("seq2_budget", budget < 20, 1);
        p1_addr = 24'h000050;
        cycle();
        chk("seq2_5th_blocked", a_cv, 0);
        p0_valid = 1; p0_we = 1; p0_addr = 24'h000100; p0_wdata = 16'h1234;
        cycle();
        chk("seq2_write_ready", a_r0, 1);
        chk("seq2_write_addr", a_addr, 24'h000100);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            rsp_valid = 1; rsp_data = 16'hB000 + 16'(i);
            cycle();
        end
        rsp_valid = 0;
        cycle();

        // controller stalls for 5 cycles
        p0_valid = 1; p0_we = 0; p0_addr = 24'h00ABCD; cmd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("seq3_stall_ready", a_r0, 0);
            chk("seq3_stall_addr", a_addr, 24'h00ABCD);
        end
        cmd_ready = 1;
        cycle();
        chk("seq3_release_ready", a_r0, 1);
        idle_inputs();
        rsp_valid = 1; rsp_data = 16'hC000;
        cycle();
        rsp_valid = 0;
        cycle();
        chk("seq3_rvalid", a_rv0, 1);

        // response with nothing outstanding
        rsp_valid = 1; rsp_data = 16'hDEAD;
        cycle();
        rsp_valid = 0;
        cycle();
        chk("seq4_no_rvalid", {a_rv0, a_rv1}, 2'b00);
        chk("seq4_tag_err", a_err, 1);
        repeat (3) cycle();
        chk("seq4_tag_err_sticky", a_err, 1);
        do_reset();
        cycle();
        chk("seq4_tag_err_cleared", a_err, 0);

        // accepted read coincides with a response
        p1_valid = 1; p1_we = 0; p1_addr = 24'h000077;
        cycle();
        chk("seq5_p1_read", a_r1, 1);
        p1_valid = 0;
        p0_valid = 1; p0_we = 0; p0_addr = 24'h000088;
        rsp_valid = 1; rsp_data = 16'hE001;
        cycle();
        chk("seq5_p0_read", a_r0, 1);
        p0_valid = 0; rsp_valid = 1; rsp_data = 16'hE002;
        cycle();
        chk("seq5_first_to_p1", {a_rv0, a_rv1}, 2'b01);
        rsp_valid = 0;
        cycle();
        chk("seq5_second_to_p0", {a_rv0, a_rv1}, 2'b10);
        chk("seq5_second_data", a_rd0, 16'hE002);
        chk("seq5_no_err", a_err, 0);

        // random traffic against the model
        idle_inputs();
        for (int c = 0; c < 1500; c++) begin
            if (e_r0 || !p0_valid) begin
                p0_valid = ($urandom_range(0, 2) != 0);
                p0_we = $urandom_range(0, 1); p0_addr = AW'($urandom);
                p0_wdata = DW'($urandom); p0_dqm = 2'($urandom);
            end
            if (e_r1 || !p1_valid) begin
                p1_valid = ($urandom_range(0, 2) != 0);
                p1_we = $urandom_range(0, 1); p1_addr = AW'($urandom);
                p1_wdata = DW'($urandom); p1_dqm = 2'($urandom);
            end
            cmd_ready = ($urandom_range(0, 3) != 0);
            rsp_valid = ($urandom_range(0, 2) == 0);
            rsp_data = DW'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
            if (rst) begin
                e_r0 = 0; e_r1 = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Two-requester arbiter sharing the single command port of the SDRAM controller inside top; runs on CLOCK_100, the same clock as the controller.
- Port 0 is the video/scan-out reader; port 1 is the CPU/test-pattern read/write master.
- Grants round-robin, forwards one command per handshake, and tags each read so returning data reaches the port that issued it.

Parameters:
- AW, 24, word address width (ba 2 + row 13 + col 9).
- DW, 16, data width; matches sdram_d.
- TAG_DEPTH, 4, maximum outstanding reads; power of two, at least 2.

Ports:
- CLOCK_100  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- p0_valid, p1_valid  in  1  request present.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  AW  word address.
- p0_wdata, p1_wdata  in  DW  write data.
- p0_dqm, p1_dqm  in  2  byte masks, active-high masking.
- p0_ready, p1_ready  out  1  request accepted this cycle.
- p0_rvalid, p1_rvalid  out  1  read data valid.
- p0_rdata, p1_rdata  out  DW  read data.
- cmd_valid  out  1  command to controller.
- cmd_ready  in  1  controller accepts.
- cmd_we  out  1  write flag to controller.
- cmd_addr  out  AW  address to controller.
- cmd_wdata  out  DW  write data to controller.
- cmd_dqm  out  2  byte masks to controller.
- rsp_valid  in  1  controller read data valid; one pulse per accepted read, in order.
- rsp_data  in  DW  controller read data.
- tag_err  out  1  sticky; rsp_valid arrived with no outstanding read.

Behaviour:
- Requester rules: a port holds valid and its payload stable until ready. A transfer happens when valid and ready are both high.
- Grant is combinational:
  - Only one port valid: that port is granted.
  - Both valid: grant the port that is not last_grant.
- last_grant register: reset value 1, so port 0 wins the first tie. It updates to the granted port only on an accepted command (cmd_valid && cmd_ready).
- Command mux: cmd_valid = (p0_valid | p1_valid) & ~rst & ~block.
  - block = tag FIFO full AND the granted request is a read.
  - Writes are never blocked by a full FIFO.
  - cmd_* payload is the granted port's payload.
- Ready: pX_ready = grantX & cmd_ready & cmd_valid. Zero added latency. At most one ready high per cycle.
- Tag FIFO:
  - Depth TAG_DEPTH, 1-bit entries.
  - Push the granted port id on an accepted read.
  - Pop on rsp_valid when the FIFO is not empty.
  - Push and pop in the same cycle: both occur and the count is unchanged. Push while full is impossible because of block.
- Response routing:
  - pX_rvalid is registered, 1-cycle latency after rsp_valid: pX_rvalid <= rsp_valid & ~empty & (head == X).
  - pX_rdata <= rsp_data, loaded on every rsp_valid for both ports.
- Empty-pop: rsp_valid while the FIFO is empty is dropped, no rvalid is raised, and tag_err <= 1. tag_err clears only on rst.
- Reset values: p0/p1_rvalid = 0, p0/p1_rdata = 0, tag_err = 0, FIFO empty, last_grant = 1. cmd_valid and both readys are 0 while rst is high.
- Reset mid-operation: outstanding tags are discarded. Responses arriving after reset count as empty-pops and set tag_err. The controller must be reset in the same cycle.

Optional Feature:
- Macro: SDRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are valid. last_grant is not implemented. This gives video a strict latency bound.
- Undefined: round-robin exactly as described in Behaviour.

Decomposition:
- Shared package sdram_pkg holds:
  - SDRAM_AW = 24, SDRAM_DW = 16.
  - Port id constants PORT_VID = 0, PORT_CPU = 1.
  - Command struct {we, addr, wdata, dqm}.
- Sub-module sdram_tag_fifo: synchronous FIFO, width 1, depth TAG_DEPTH, with full/empty flags and simultaneous push/pop support.

Test Plan:
1. Both ports issue reads with cmd_ready = 1 and 4 cycles each → grants alternate 0,1,0,1. Controller returns data 0xA000..0xA003 → p0_rdata 0xA000, 0xA002 and p1_rdata 0xA001, 0xA003, each 1 cycle after rsp_valid.
2. Hold rsp_valid low and issue 4 reads from p1 → the 5th read is blocked (cmd_valid = 0). A p0 write with addr 0x000100 and wdata 0x1234 is still accepted.
3. cmd_ready held low for 5 cycles with p0 valid → p0_ready stays 0 and cmd_addr stays stable. The cycle cmd_ready rises, p0_ready = 1.
4. rsp_valid pulses with no reads outstanding → no rvalid on either port and tag_err = 1. tag_err stays set until rst.
5. An accepted read and rsp_valid occur in the same cycle with 1 read outstanding → the count stays at 1 and the routing order is preserved.
6. With SDRAM_ARB_FIXED_PRIO_EN defined and both ports valid for 3 commands → p0 is granted 3 times and p1 is granted only after p0_valid drops.
